// File: rtl/npc_bpred.sv
// npc_bpred: next-PC unit with a direct-mapped BTB and 2-bit saturating
// counters. Owns the fetch PC, predicts at IF and resolves at EX, redirecting
// fetch on a mispredict. The PC is word-addressed, so the sequential successor
// is pc+1.
//
// Optional statistics counters are compiled in with `define BPRED_STATS_EN.
// Without the macro, branch_cnt and mispred_cnt are tied to zero.
//
// This block has no FSM and no valid/ready handshakes. ex_valid marks a
// single-cycle EX presentation. It is never back-pressured.
`timescale 1ns/1ps

module npc_bpred #(
    parameter int               WIDTH     = 32,
    parameter int               BTB_DEPTH = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt,
    input  logic             stall,
    output logic [WIDTH-1:0] pc_if,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target,
    input  logic             ex_valid,
    input  logic [WIDTH-1:0] pc_ex,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] index,
    input  logic [WIDTH-1:0] offset,
    input  logic             EQ,
    input  logic             j,
    input  logic             jal,
    input  logic             jr,
    input  logic             beq,
    input  logic             bne,
    input  logic             blez,
    input  logic             ex_pred_taken,
    input  logic [WIDTH-1:0] ex_pred_target,
    output logic             correct_b,
    output logic             mispredict,
    output logic [31:0]      branch_cnt,
    output logic [31:0]      mispred_cnt
);

    localparam int               IDX_W = $clog2(BTB_DEPTH);
    localparam int               TAG_W = WIDTH - IDX_W;
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    // Fetch PC register
    logic [WIDTH-1:0] pc_if_q, pc_if_d;

    // BTB storage: valid, tag, target and 2-bit counter per entry
    logic             valid_q  [BTB_DEPTH];
    logic             valid_d  [BTB_DEPTH];
    logic [TAG_W-1:0] tag_q    [BTB_DEPTH];
    logic [TAG_W-1:0] tag_d    [BTB_DEPTH];
    logic [WIDTH-1:0] target_q [BTB_DEPTH];
    logic [WIDTH-1:0] target_d [BTB_DEPTH];
    logic [1:0]       ctr_q    [BTB_DEPTH];
    logic [1:0]       ctr_d    [BTB_DEPTH];

    // IF lookup
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    // EX resolution
    logic             is_ctrl;
    logic             act_taken;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] act_target;
    logic [WIDTH-1:0] resolved;
    logic             upd_en;

    // EX-side BTB update addressing
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    assign pc_if = pc_if_q;

    // IF lookup from the registered fetch PC. The lookup sees the
    // pre-update BTB contents.
    always_comb begin
        lk_idx      = pc_if_q[IDX_W-1:0];
        lk_tag      = pc_if_q[WIDTH-1:IDX_W];
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = lk_hit && ctr_q[lk_idx][1];
        pred_target = pred_taken ? target_q[lk_idx] : (pc_if_q + ONE);
    end

    // EX resolution: actual direction and target, plus mispredict detection
    always_comb begin
        correct_b  = (EQ & beq) | (~EQ & bne) | ((EQ | A[WIDTH-1]) & blez);
        is_ctrl    = j | jal | jr | beq | bne | blez;
        act_taken  = j | jal | jr | correct_b;
        br_target  = pc_ex + ONE + offset;
        if (jr) begin
            act_target = A;
        end else if (j | jal) begin
            act_target = index;
        end else begin
            act_target = br_target;
        end
        resolved   = act_taken ? act_target : (pc_ex + ONE);
        upd_en     = ex_valid & ~halt;
        mispredict = upd_en &
                     ((ex_pred_taken != act_taken) |
                      (act_taken & (ex_pred_target != act_target)));
    end

    // Next fetch PC: halt wins, then the redirect (even under stall), then
    // stall, then the prediction
    always_comb begin
        if (halt) begin
            pc_if_d = pc_ex;
        end else if (mispredict) begin
            pc_if_d = resolved;
        end else if (stall) begin
            pc_if_d = pc_if_q;
        end else begin
            pc_if_d = pred_target;
        end
    end

    // BTB training from the EX instruction. stall does not block it; halt does.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        up_idx   = pc_ex[IDX_W-1:0];
        up_tag   = pc_ex[WIDTH-1:IDX_W];
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        if (upd_en) begin
            if (is_ctrl) begin
                if (up_hit) begin
                    if (act_taken) begin
                        if (ctr_q[up_idx] != 2'b11) begin
                            ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                        end
                        target_d[up_idx] = act_target;
                    end else if (ctr_q[up_idx] != 2'b00) begin
                        ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                    end
                end else if (act_taken) begin
                    // Allocate or replace the entry, starting at weakly taken
                    valid_d[up_idx]  = 1'b1;
                    tag_d[up_idx]    = up_tag;
                    target_d[up_idx] = act_target;
                    ctr_d[up_idx]    = 2'b10;
                end
            end else if (up_hit) begin
                // A non-control instruction aliased onto a branch entry: drop it
                valid_d[up_idx] = 1'b0;
            end
        end
    end

    // State registers: fetch PC and BTB arrays
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_if_q <= RESET_PC;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            pc_if_q <= pc_if_d;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
        end
    end

`ifdef BPRED_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    // Saturating counts of resolved control instructions and mispredicts
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_en && is_ctrl && (branch_cnt_q != 32'hFFFF_FFFF)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`else
    assign branch_cnt  = 32'd0;
    assign mispred_cnt = 32'd0;
`endif

endmodule

// File: doc/npc_bpred.md
Name: npc_bpred

Overview:
- Next-PC unit with dynamic branch prediction.
- Owns the fetch PC register and predicts the next PC at IF from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Resolves jumps and branches at EX and redirects fetch on a mispredict.
- Word-addressed PC: sequential successor is pc+1.

Parameters:
WIDTH, 32, PC/data width in bits
BTB_DEPTH, 16, BTB entries; power of two, >=2
IDX_W, $clog2(BTB_DEPTH), index bits (derived, not overridden)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
halt  in  1  halt instruction in EX; PC returns to pc_ex
stall  in  1  freeze fetch PC
pc_if  out  WIDTH  current fetch PC (registered)
pred_taken  out  1  IF prediction for pc_if
pred_target  out  WIDTH  predicted next PC for pc_if
ex_valid  in  1  EX holds a valid instruction, presented for exactly one cycle
pc_ex  in  WIDTH  PC of EX instruction
A  in  WIDTH  rs operand (jr target, blez sign)
index  in  WIDTH  j/jal target, already extended
offset  in  WIDTH  sign-extended branch offset
EQ  in  1  operands equal
j, jal, jr, beq, bne, blez  in  1 each  EX decode
ex_pred_taken  in  1  prediction piped from IF with this instruction
ex_pred_target  in  WIDTH  predicted next PC piped from IF
correct_b  out  1  (EQ&beq)|(~EQ&bne)|((EQ|A[WIDTH-1])&blez)
mispredict  out  1  flush IF/ID, redirect fetch
branch_cnt  out  32  resolved control instructions (feature)
mispred_cnt  out  32  mispredicts (feature)

Behaviour:
- Reset (async, rst_n=0):
  - pc_if=RESET_PC.
  - All BTB valid bits=0; counters=2'b01.
  - Stat counters=0.
  - Combinational outputs follow from the cleared state: pred_taken=0, pred_target=RESET_PC+1, mispredict=0.
- Lookup (combinational on pc_if):
  - idx=pc_if[IDX_W-1:0], tag=pc_if[WIDTH-1:IDX_W].
  - hit = valid[idx] & tag match.
  - pred_taken = hit & ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : pc_if+1.
- Resolution (combinational, EX):
  - is_ctrl = j|jal|jr|beq|bne|blez.
  - act_taken = j|jal|jr|correct_b.
  - act_target = jr ? A : (j|jal) ? index : pc_ex+1+offset.
  - resolved = act_taken ? act_target : pc_ex+1.
  - All sums are modulo 2^WIDTH.
- mispredict = ex_valid & ~halt & (ex_pred_taken!=act_taken | (act_taken & ex_pred_target!=act_target)).
  - A non-control instruction predicted taken (alias) counts as a mispredict; resolved=pc_ex+1.
- PC update priority per clock: halt -> pc_if<=pc_ex; else mispredict -> resolved (overrides stall); else stall -> hold; else pred_target.
- BTB update, at the clock edge when ex_valid & ~halt, entry indexed by pc_ex:
  - Control, entry hit: counter +1 if taken, -1 if not, saturating at 00 and 11. If taken, target<=act_target.
  - Control, entry miss, taken: allocate/replace: valid=1, tag, target=act_target, ctr=2'b10.
  - Control, entry miss, not taken: no change.
  - Non-control, entry hit: clear valid.
- stall does not block BTB updates.
- Lookup and update at the same index in the same cycle: lookup sees pre-update contents (read-before-write).
- Update latency: one cycle; the earliest lookup reflecting an update is the next cycle.

Optional Feature:
BPRED_STATS_EN
- Defined: when ex_valid & ~halt, branch_cnt increments on is_ctrl and mispred_cnt increments on mispredict. Both saturate at 32'hFFFFFFFF; reset to 0.
- Undefined: both ports remain present and are tied to 0; no counter logic.

Test Plan:
- Reset then release with no stall: pc_if=0,1,2,3 on successive clocks; pred_taken=0 throughout.
- beq at pc_ex=5, EQ=1, offset=3, ex_pred_taken=0 -> mispredict=1, pc_if=9 next clock, BTB[5] valid with target=9 and ctr=10. When pc_if later equals 5 -> pred_taken=1, pred_target=9.
- Same branch resolved taken twice more (ctr=11), then not-taken -> ctr=10, still predicts taken. A second not-taken -> ctr=01, pred_target=6, and that resolution mispredicts with pc_if<=6.
- jr at pc_ex=0x20, A=0x40, ex_pred_taken=1, ex_pred_target=0x30 -> mispredict=1, pc_if=0x40, BTB target updated to 0x40. Simultaneously assert stall -> redirect still taken.
- halt with pc_ex=7 and mispredicting inputs -> mispredict=0, pc_if=7 next clock, BTB and stat counters unchanged.
- DEPTH=16, entry trained at pc 0x05, then lookup at pc_if=0x15 -> pred_taken=0. Non-control instruction at pc_ex=0x05 with ex_pred_taken=1 -> mispredict, pc_if=0x06, entry invalidated. With BPRED_STATS_EN, mispred_cnt increments and branch_cnt does not.
